// File: rtl/ct_f_spsram_arb_pkg.sv
// Shared types and constants for the 256x52 single-port SRAM sequencer/arbiter.
package ct_f_spsram_arb_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } arb_state_e;

  localparam int NUM_PORTS = 2;

  // A one-hot two-way grant maps to its port id by its upper bit.
  function automatic logic gnt_to_id(input logic [NUM_PORTS-1:0] gnt);
    return gnt[1];
  endfunction

endpackage

// File: rtl/ct_f_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant when enabled, pointer flips to the other port after a grant.
module ct_f_rr_arb2
  import ct_f_spsram_arb_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_PORTS-1:0] vld,
  input  logic                 en,
  output logic [NUM_PORTS-1:0] gnt,
  output logic                 gnt_id
);

  logic ptr;

  // ptr names the port that wins a tie; a lone requester always wins.
  always_comb begin
    gnt = '0;
    if (en) begin
      case (vld)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign gnt_id = gnt_to_id(gnt);

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr <= 1'b0;
    end else if (|gnt) begin
      ptr <= ~gnt_id;
    end
  end

endmodule

// File: rtl/ct_f_spsram_256x52_arb.sv
// Zero-fills a 256x52 single-port sync SRAM after reset or on request, then shares its port
// between two clients with round-robin arbitration and a fixed one-cycle read latency.
module ct_f_spsram_256x52_arb
  import ct_f_spsram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 52,
  parameter int WRAP_SIZE  = 26
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  init_req,
  output logic                  init_done,
  input  logic                  p0_req_vld,
  output logic                  p0_req_rdy,
  input  logic                  p0_req_wr,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  input  logic [DATA_WIDTH-1:0] p0_req_wdata,
  input  logic [1:0]            p0_req_wbe,
  output logic                  p0_rsp_vld,
  input  logic                  p1_req_vld,
  output logic                  p1_req_rdy,
  input  logic                  p1_req_wr,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  input  logic [DATA_WIDTH-1:0] p1_req_wdata,
  input  logic [1:0]            p1_req_wbe,
  output logic                  p1_rsp_vld,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] A,
  output logic                  CEN,
  output logic                  GWEN,
  output logic [DATA_WIDTH-1:0] WEN,
  output logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] Q
);

  localparam logic [ADDR_WIDTH-1:0] INIT_LAST = '1;

  arb_state_e            state;
  arb_state_e            state_nxt;
  logic [ADDR_WIDTH-1:0] init_cnt;

  logic [NUM_PORTS-1:0]  req_vld;
  logic [NUM_PORTS-1:0]  gnt;
  logic                  gnt_id;
  logic                  gnt_any;
  logic                  arb_en;

  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [1:0]            sel_wbe;
  logic [DATA_WIDTH-1:0] sel_wen;

  logic                  rsp_vld_q;
  logic                  rsp_id_q;

  // Grants only in RUN, and never in the cycle that requests a re-initialisation.
  assign req_vld = {p1_req_vld, p0_req_vld};
  assign arb_en  = (state == RUN) && !init_req && !RST;

  ct_f_rr_arb2 u_rr_arb (
    .CLK    (CLK),
    .RST    (RST),
    .vld    (req_vld),
    .en     (arb_en),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign gnt_any    = |gnt;
  assign p0_req_rdy = gnt[0];
  assign p1_req_rdy = gnt[1];

  assign sel_wr    = gnt_id ? p1_req_wr    : p0_req_wr;
  assign sel_addr  = gnt_id ? p1_req_addr  : p0_req_addr;
  assign sel_wdata = gnt_id ? p1_req_wdata : p0_req_wdata;
  assign sel_wbe   = gnt_id ? p1_req_wbe   : p0_req_wbe;
  assign sel_wen   = {{WRAP_SIZE{~sel_wbe[1]}}, {WRAP_SIZE{~sel_wbe[0]}}};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (init_cnt == INIT_LAST) state_nxt = RUN;
      RUN:     if (init_req) state_nxt = INIT;
      default: state_nxt = INIT;
    endcase
  end

  // The counter wraps to zero on the last fill write, so a later init_req starts from zero too.
  always_ff @(posedge CLK) begin
    if (RST) begin
      init_cnt <= '0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + 1'b1;
    end else if (init_req) begin
      init_cnt <= '0;
    end
  end

  // SRAM pins idle while RST is held, regardless of the registered state.
  always_comb begin
    CEN       = 1'b1;
    GWEN      = 1'b1;
    WEN       = '1;
    A         = '0;
    D         = '0;
    init_done = 1'b0;
    if (!RST) begin
      case (state)
        INIT: begin
          CEN  = 1'b0;
          GWEN = 1'b0;
          WEN  = '0;
          A    = init_cnt;
        end
        RUN: begin
          init_done = 1'b1;
          if (gnt_any) begin
            CEN = 1'b0;
            A   = sel_addr;
            if (sel_wr) begin
              GWEN = ~|sel_wbe;
              WEN  = sel_wen;
              D    = sel_wdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Remembers which port owns the data that the SRAM presents on Q in the next cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= 1'b0;
    end else begin
      rsp_vld_q <= gnt_any && !sel_wr;
      rsp_id_q  <= gnt_id;
    end
  end

  assign p0_rsp_vld = rsp_vld_q && !rsp_id_q && !RST;
  assign p1_rsp_vld = rsp_vld_q &&  rsp_id_q && !RST;
  assign rsp_data   = Q;

endmodule

// File: tb/tb_ct_f_spsram_256x52_arb.sv
// Bench for ct_f_spsram_256x52_arb: behavioural SRAM, reference memory and a response scoreboard.
module tb_ct_f_spsram_256x52_arb;

  logic        CLK = 1'b0;
  logic        RST;
  logic        init_req;
  logic        init_done;
  logic        req_vld[2];
  logic        req_wr[2];
  logic [7:0]  req_addr[2];
  logic [51:0] req_wdata[2];
  logic [1:0]  req_wbe[2];
  logic        p_rdy[2];
  logic        p0_rsp_vld;
  logic        p1_rsp_vld;
  logic [51:0] rsp_data;
  logic [7:0]  A;
  logic        CEN;
  logic        GWEN;
  logic [51:0] WEN;
  logic [51:0] D;
  logic [51:0] Q;

  typedef struct {
    int          port;
    logic [51:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [51:0] sram[256];
  logic [51:0] ref_mem[256];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  ct_f_spsram_256x52_arb dut (
    .CLK          (CLK),
    .RST          (RST),
    .init_req     (init_req),
    .init_done    (init_done),
    .p0_req_vld   (req_vld[0]),
    .p0_req_rdy   (p_rdy[0]),
    .p0_req_wr    (req_wr[0]),
    .p0_req_addr  (req_addr[0]),
    .p0_req_wdata (req_wdata[0]),
    .p0_req_wbe   (req_wbe[0]),
    .p0_rsp_vld   (p0_rsp_vld),
    .p1_req_vld   (req_vld[1]),
    .p1_req_rdy   (p_rdy[1]),
    .p1_req_wr    (req_wr[1]),
    .p1_req_addr  (req_addr[1]),
    .p1_req_wdata (req_wdata[1]),
    .p1_req_wbe   (req_wbe[1]),
    .p1_rsp_vld   (p1_rsp_vld),
    .rsp_data     (rsp_data),
    .A            (A),
    .CEN          (CEN),
    .GWEN         (GWEN),
    .WEN          (WEN),
    .D            (D),
    .Q            (Q)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural sync single-port SRAM with active-low per-bit write enables.
  initial begin
    logic [63:0] tmp;
    Q = '0;
    for (int i = 0; i < 256; i++) begin
      tmp = {$urandom(), $urandom()};
      sram[i] = tmp[51:0];
      ref_mem[i] = '0;
    end
  end

  always @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) sram[A] <= (sram[A] & WEN) | (D & ~WEN);
      else       Q <= sram[A];
    end
  end

  // Scoreboard: pop/compare responses, then record newly accepted requests.
  always @(negedge CLK) begin
    exp_t e;
    int   got_port;
    if (RST) begin
      checks++;
      if (p0_rsp_vld !== 1'b0 || p1_rsp_vld !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rsp_in_reset: p0_rsp_vld=%b p1_rsp_vld=%b, required 0/0", p0_rsp_vld, p1_rsp_vld);
      end
      sb.delete();
    end else begin
      if (p0_rsp_vld === 1'b1 || p1_rsp_vld === 1'b1) begin
        checks++;
        got_port = p1_rsp_vld ? 1 : 0;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL rsp_unexpected: port %0d data %h with no read outstanding", got_port, rsp_data);
        end else begin
          e = sb.pop_front();
          if ((p0_rsp_vld && p1_rsp_vld) || got_port != e.port || rsp_data !== e.data || e.due != cyc) begin
            errors++;
            $display("[TB] FAIL rsp_match: got port %0d data %h cycle %0d (vld %b%b), required port %0d data %h cycle %0d",
                     got_port, rsp_data, cyc, p1_rsp_vld, p0_rsp_vld, e.port, e.data, e.due);
          end
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        checks++;
        errors++;
        e = sb.pop_front();
        $display("[TB] FAIL rsp_missing: no rsp_vld at cycle %0d, required port %0d data %h", cyc, e.port, e.data);
      end
      for (int n = 0; n < 2; n++) begin
        checks++;
        if (p_rdy[n] === 1'b1 && req_vld[n] !== 1'b1) begin
          errors++;
          $display("[TB] FAIL rdy_without_vld: port %0d rdy=1 vld=%b, required rdy=0", n, req_vld[n]);
        end
        if (p_rdy[n] === 1'b1 && req_vld[n] === 1'b1) begin
          if (req_wr[n]) begin
            if (req_wbe[n][0]) ref_mem[req_addr[n]][25:0]  = req_wdata[n][25:0];
            if (req_wbe[n][1]) ref_mem[req_addr[n]][51:26] = req_wdata[n][51:26];
          end else begin
            e.port = n;
            e.data = ref_mem[req_addr[n]];
            e.due  = cyc + 1;
            sb.push_back(e);
          end
        end
      end
    end
  end

  task automatic clear_ref();
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
  endtask

  // Holds RST for n cycles, checking idle pins; returns at posedge+1 with RST released.
  task automatic apply_reset(input int n);
    RST = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      checks++;
      if (CEN !== 1'b1 || GWEN !== 1'b1 || WEN !== {52{1'b1}} || A !== 8'd0 || D !== 52'd0 ||
          p_rdy[0] !== 1'b0 || p_rdy[1] !== 1'b0 || init_done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_pins: CEN=%b GWEN=%b WEN=%h A=%h D=%h rdy=%b%b init_done=%b, required 1 1 all-ones 0 0 00 0",
                 CEN, GWEN, WEN, A, D, p_rdy[1], p_rdy[0], init_done);
      end
      @(posedge CLK); #1;
    end
    clear_ref();
    RST = 1'b0;
  endtask

  // Checks n fill cycles; when full, the cycle after the sweep must show init_done.
  task automatic init_sweep(input int n, input bit full);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      checks++;
      if (CEN !== 1'b0 || GWEN !== 1'b0 || WEN !== 52'd0 || D !== 52'd0 || A !== i[7:0] ||
          init_done !== 1'b0 || p_rdy[0] !== 1'b0 || p_rdy[1] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL init_fill[%0d]: CEN=%b GWEN=%b WEN=%h D=%h A=%h init_done=%b rdy=%b%b, required 0 0 0 0 %h 0 00",
                 i, CEN, GWEN, WEN, D, A, init_done, p_rdy[1], p_rdy[0], i[7:0]);
      end
      @(posedge CLK); #1;
    end
    if (full) begin
      req_vld[0] = 1'b0;
      req_vld[1] = 1'b0;
      @(negedge CLK);
      checks++;
      if (init_done !== 1'b1 || CEN !== 1'b1) begin
        errors++;
        $display("[TB] FAIL init_done_after_fill: init_done=%b CEN=%b, required 1 1", init_done, CEN);
      end
      @(posedge CLK); #1;
    end
  endtask

  // Presents one request on a port until granted, checking the SRAM pins in the grant cycle.
  task automatic issue(input int port, input logic wr, input logic [7:0] addr,
                       input logic [51:0] data, input logic [1:0] wbe);
    logic [51:0] exp_wen;
    logic        exp_gwen;
    bit          got;
    exp_wen  = wr ? {{26{~wbe[1]}}, {26{~wbe[0]}}} : {52{1'b1}};
    exp_gwen = !(wr && (wbe != 2'b00));
    req_wr[port]    = wr;
    req_addr[port]  = addr;
    req_wdata[port] = data;
    req_wbe[port]   = wbe;
    req_vld[port]   = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge CLK);
      if (p_rdy[port] === 1'b1) begin
        got = 1'b1;
        checks++;
        if (CEN !== 1'b0 || A !== addr || GWEN !== exp_gwen || WEN !== exp_wen || (wr && D !== data)) begin
          errors++;
          $display("[TB] FAIL grant_pins p%0d: CEN=%b A=%h GWEN=%b WEN=%h D=%h, required 0 %h %b %h %h",
                   port, CEN, A, GWEN, WEN, D, addr, exp_gwen, exp_wen, data);
        end
      end
      @(posedge CLK); #1;
    end
    req_vld[port] = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL grant_timeout p%0d: rdy=0 for 8 cycles, required a grant", port);
    end
  endtask

  task automatic test_reset();
    req_vld[0] = 1'b1;
    req_vld[1] = 1'b1;
    apply_reset(3);
    req_vld[1] = 1'b0;
    init_sweep(256, 1'b1);
  endtask

  task automatic test_write_read();
    issue(0, 1'b1, 8'h10, 52'hA_BCDE_F012_3456, 2'b11);
    issue(0, 1'b0, 8'h10, 52'd0, 2'b00);
    @(negedge CLK);
    checks++;
    if (p0_rsp_vld !== 1'b1 || p1_rsp_vld !== 1'b0 || rsp_data !== 52'hA_BCDE_F012_3456) begin
      errors++;
      $display("[TB] FAIL write_read: p0_rsp_vld=%b p1_rsp_vld=%b data=%h, required 1 0 %h",
               p0_rsp_vld, p1_rsp_vld, rsp_data, 52'hA_BCDE_F012_3456);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_partial_write();
    issue(0, 1'b1, 8'h20, 52'hF_FFFF_FFFF_FFFF, 2'b01);
    issue(0, 1'b0, 8'h20, 52'd0, 2'b00);
    @(negedge CLK);
    checks++;
    if (p0_rsp_vld !== 1'b1 || rsp_data !== 52'h0_0000_03FF_FFFF) begin
      errors++;
      $display("[TB] FAIL partial_low: p0_rsp_vld=%b data=%h, required 1 %h", p0_rsp_vld, rsp_data, 52'h0_0000_03FF_FFFF);
    end
    @(posedge CLK); #1;
    issue(1, 1'b1, 8'h30, 52'h1_2345_6789_ABCD, 2'b10);
    issue(1, 1'b0, 8'h30, 52'd0, 2'b00);
    issue(0, 1'b1, 8'h10, 52'h5_5555_5555_5555, 2'b00);
    issue(0, 1'b0, 8'h10, 52'd0, 2'b00);
    @(negedge CLK);
    checks++;
    if (p0_rsp_vld !== 1'b1 || rsp_data !== 52'hA_BCDE_F012_3456) begin
      errors++;
      $display("[TB] FAIL wbe00_no_change: p0_rsp_vld=%b data=%h, required 1 %h", p0_rsp_vld, rsp_data, 52'hA_BCDE_F012_3456);
    end
    @(posedge CLK); #1;
  endtask

  // Last grant before this was port 0, so port 1 must win the first tie.
  task automatic test_back_to_back();
    int exp_port;
    int got_port;
    req_wr[0] = 1'b0; req_addr[0] = 8'h10;
    req_wr[1] = 1'b0; req_addr[1] = 8'h20;
    req_vld[0] = 1'b1;
    req_vld[1] = 1'b1;
    exp_port = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      checks++;
      got_port = p_rdy[1] ? 1 : 0;
      if ((p_rdy[0] ^ p_rdy[1]) !== 1'b1 || got_port != exp_port) begin
        errors++;
        $display("[TB] FAIL rr_alternate[%0d]: rdy=%b%b, required port %0d only", k, p_rdy[1], p_rdy[0], exp_port);
      end
      exp_port = 1 - exp_port;
      @(posedge CLK); #1;
    end
    req_vld[0] = 1'b0;
    req_vld[1] = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_init_req();
    req_wr[0] = 1'b0; req_addr[0] = 8'h10; req_vld[0] = 1'b1;
    @(negedge CLK);
    checks++;
    if (p_rdy[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_init_read: rdy=%b, required 1", p_rdy[0]);
    end
    @(posedge CLK); #1;
    init_req = 1'b1;
    clear_ref();
    @(negedge CLK);
    checks++;
    if (p_rdy[0] !== 1'b0 || CEN !== 1'b1 || init_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL init_req_cycle: rdy=%b CEN=%b init_done=%b, required 0 1 1", p_rdy[0], CEN, init_done);
    end
    @(posedge CLK); #1;
    init_req = 1'b0;
    init_sweep(256, 1'b1);
    issue(0, 1'b0, 8'h10, 52'd0, 2'b00);
    @(negedge CLK);
    checks++;
    if (p0_rsp_vld !== 1'b1 || rsp_data !== 52'd0) begin
      errors++;
      $display("[TB] FAIL reinit_zero: p0_rsp_vld=%b data=%h, required 1 0", p0_rsp_vld, rsp_data);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_midway();
    issue(1, 1'b1, 8'h40, 52'h7_7777_7777_7777, 2'b11);
    issue(1, 1'b0, 8'h40, 52'd0, 2'b00);
    apply_reset(2);
    init_sweep(100, 1'b0);
    apply_reset(1);
    init_sweep(256, 1'b1);
    issue(1, 1'b0, 8'h40, 52'd0, 2'b00);
    repeat (2) begin
      @(posedge CLK); #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d responses outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    RST = 1'b1;
    init_req = 1'b0;
    for (int n = 0; n < 2; n++) begin
      req_vld[n] = 1'b0; req_wr[n] = 1'b0; req_addr[n] = '0; req_wdata[n] = '0; req_wbe[n] = '0;
    end
    test_reset();
    test_write_read();
    test_partial_write();
    test_back_to_back();
    test_init_req();
    test_reset_midway();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
